// File: rtl/key_press_generator.sv
// Key press waveform synthesiser: one short/long press per accepted command, then a gap, then done.
// Optional KEY_GEN_REPEAT_EN adds cmd_repeat[3:0] to run the press+gap pair 1-16 times per command.
module key_press_generator #(
  parameter logic [31:0] SHORT_PRESS_TIME = 32'd10000000,
  parameter logic [31:0] LONG_HOLD_TIME   = 32'd350000000,
  parameter logic [31:0] GAP_TIME         = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_long,
`ifdef KEY_GEN_REPEAT_EN
  input  logic [3:0] cmd_repeat,
`endif
  output logic       cmd_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done
);

  // A zero-length phase would underflow the terminal compare, so clamp to one cycle.
  localparam logic [31:0] SHORT_EFF = (SHORT_PRESS_TIME == 32'd0) ? 32'd1 : SHORT_PRESS_TIME;
  localparam logic [31:0] LONG_EFF  = (LONG_HOLD_TIME   == 32'd0) ? 32'd1 : LONG_HOLD_TIME;
  localparam logic [31:0] GAP_EFF   = (GAP_TIME         == 32'd0) ? 32'd1 : GAP_TIME;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]  state;
  logic [31:0] cnt;
  logic        long_q;
  logic [31:0] hold_m1;
  logic        last_rep;

  assign hold_m1   = long_q ? (LONG_EFF - 32'd1) : (SHORT_EFF - 32'd1);
  assign cmd_ready = (state == S_IDLE);

`ifdef KEY_GEN_REPEAT_EN
  logic [3:0] rep_tgt;
  logic [3:0] rep_cnt;
  assign last_rep = (rep_cnt == rep_tgt);
`else
  assign last_rep = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 32'd0;
      long_q  <= 1'b0;
      key_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef KEY_GEN_REPEAT_EN
      rep_tgt <= 4'd0;
      rep_cnt <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state   <= S_PRESS;
            cnt     <= 32'd0;
            long_q  <= cmd_long;
            key_out <= 1'b1;
            busy    <= 1'b1;
`ifdef KEY_GEN_REPEAT_EN
            rep_tgt <= cmd_repeat;
            rep_cnt <= 4'd0;
`endif
          end
        end
        S_PRESS: begin
          if (cnt == hold_m1) begin
            state   <= S_GAP;
            cnt     <= 32'd0;
            key_out <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_EFF - 32'd1) begin
            cnt <= 32'd0;
            if (last_rep) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Next press of a repeated command reuses the latched hold length.
              state   <= S_PRESS;
              key_out <= 1'b1;
`ifdef KEY_GEN_REPEAT_EN
              rep_cnt <= rep_cnt + 4'd1;
`endif
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= 32'd0;
          key_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_generator.sv
// Directed bench for key_press_generator: per-cycle expected outputs are queued when a command
// is driven and popped/compared each cycle on the falling clock edge.
module tb_key_press_generator;

  localparam int SHORT = 4;
  localparam int LONG  = 10;
  localparam int GAP   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_long = 1'b0;
`ifdef KEY_GEN_REPEAT_EN
  logic [3:0] cmd_repeat = 4'd0;
`endif
  logic cmd_ready, key_out, busy, done;

  typedef struct {
    logic key;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   hi_cnt;

  always #5 clk = ~clk;

  key_press_generator #(
    .SHORT_PRESS_TIME(32'd4),
    .LONG_HOLD_TIME  (32'd10),
    .GAP_TIME        (32'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_long  (cmd_long),
`ifdef KEY_GEN_REPEAT_EN
    .cmd_repeat(cmd_repeat),
`endif
    .cmd_ready (cmd_ready),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%0b exp=%0b", tag, act, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic push(input logic k, input logic b, input logic d, input logic r);
    exp_t e;
    e.key = k; e.busy = b; e.done = d; e.ready = r;
    sbq.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one command, starting the cycle after accept.
  task automatic push_cmd(input bit lng, input int reps);
    int hold;
    hold = lng ? LONG : SHORT;
    for (int r = 0; r <= reps; r++) begin
      for (int i = 0; i < hold; i++) push(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < GAP; i++)  push(1'b0, 1'b1, 1'b0, 1'b0);
    end
    push(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    e = sbq.pop_front();
    chk({tag, ".key"},   key_out,   e.key);
    chk({tag, ".busy"},  busy,      e.busy);
    chk({tag, ".done"},  done,      e.done);
    chk({tag, ".ready"}, cmd_ready, e.ready);
  endtask

  // Called at a falling edge; the command is accepted on the following rising edge.
  task automatic run_cmd(input string tag, input bit lng, input int reps, input bit hold_valid);
    cmd_valid = 1'b1;
    cmd_long  = lng;
`ifdef KEY_GEN_REPEAT_EN
    cmd_repeat = 4'(reps);
`endif
    push_cmd(lng, reps);
    hi_cnt = 0;
    while (sbq.size() > 0) begin
      @(negedge clk);
      if (hold_valid) cmd_long = ~cmd_long;
      else cmd_valid = 1'b0;
      if (key_out === 1'b1) hi_cnt++;
      check_cycle(tag);
    end
    chk_int({tag, ".hi_cycles"}, hi_cnt, (lng ? LONG : SHORT) * (reps + 1));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check_cycle(tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("por.key", key_out, 1'b0);
    chk("por.busy", busy, 1'b0);
    chk("por.done", done, 1'b0);
    chk("por.ready", cmd_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles("idle0", 2);

    // Reset mid-idle, observed without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idle.key", key_out, 1'b0);
    chk("rst_idle.busy", busy, 1'b0);
    chk("rst_idle.done", done, 1'b0);
    chk("rst_idle.ready", cmd_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles("idle1", 1);

    run_cmd("short", 1'b0, 0, 1'b0);
    idle_cycles("idle2", 2);
    run_cmd("long", 1'b1, 0, 1'b0);
    idle_cycles("idle3", 1);

    // cmd_valid held with cmd_long toggling; second command lands in the done cycle
    run_cmd("toggle", 1'b0, 0, 1'b1);
    run_cmd("b2b", 1'b0, 0, 1'b0);
    idle_cycles("idle4", 1);

    // Reset during PRESS cycle 2
    cmd_valid = 1'b1; cmd_long = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    chk("rp.c1.key", key_out, 1'b1);
    @(negedge clk);
    chk("rp.c2.key", key_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rp.key", key_out, 1'b0);
    chk("rp.busy", busy, 1'b0);
    chk("rp.done", done, 1'b0);
    chk("rp.ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rp.hold.done", done, 1'b0);
      chk("rp.hold.key", key_out, 1'b0);
    end
    rst_n = 1'b1;
    idle_cycles("rp.idle", 2);
    run_cmd("rp.short", 1'b0, 0, 1'b0);
    idle_cycles("idle5", 1);

`ifdef KEY_GEN_REPEAT_EN
    run_cmd("repeat", 1'b0, 2, 1'b0);
    idle_cycles("idle6", 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
